// File: rtl/powlib_sfifo_lvl.sv
// ============================================================================
// Module   : powlib_sfifo_lvl
// Brief    : Single-clock valid/ready FIFO, full-depth (any D >= 2), with
//            occupancy level, almost-full/empty flags, flush, optional
//            registered output stage.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module powlib_sfifo_lvl #(
    parameter int    W     = 16,
    parameter int    D     = 8,
    parameter int    EOREG = 0,
    parameter int    AFT   = 6,
    parameter int    AET   = 2,
    parameter int    EDBG  = 0,
    parameter string ID    = "SFIFOL",
    localparam int   LW    = $clog2(D + EOREG + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [W-1:0]  wrdata,
    input  logic          wrvld,
    output logic          wrrdy,
    output logic [W-1:0]  rddata,
    output logic          rdvld,
    input  logic          rdrdy,
    output logic [LW-1:0] lvl,
    output logic          afull,
    output logic          aempty
);

    localparam int            C_CAP  = D + EOREG;
    localparam int            WPTR   = $clog2(D);
    localparam logic [LW-1:0] c_CAP  = LW'(C_CAP);
    localparam logic [LW-1:0] c_AFT  = LW'(AFT);
    localparam logic [LW-1:0] c_AET  = LW'(AET);

    if (EDBG != 0 && (D < 2 || AFT < 1 || AFT > C_CAP || AET < 0 || AET > C_CAP - 1)) begin : g_badparam
        $error("%s: illegal parameters D=%0d EOREG=%0d AFT=%0d AET=%0d", ID, D, EOREG, AFT, AET);
    end

    logic [W-1:0]    r_ram [D];
    logic [WPTR-1:0] r_wrptr;
    logic [WPTR-1:0] r_rdptr;
    logic [LW-1:0]   r_lvl;
    logic            w_wr;
    logic            w_rd;
    logic            w_rpop;
    logic            w_hvld;
    logic [W-1:0]    w_ramq;

    // Pointers wrap explicitly at D-1 so non-power-of-two depths use every slot.
    function automatic logic [WPTR-1:0] f_inc(input logic [WPTR-1:0] p);
        return (p == WPTR'(D - 1)) ? '0 : p + WPTR'(1);
    endfunction

    assign wrrdy  = (r_lvl != c_CAP) && !clr;
    assign rdvld  = w_hvld && !clr;
    assign w_wr   = wrvld && wrrdy;
    assign w_rd   = rdvld && rdrdy;
    assign w_ramq = r_ram[r_rdptr];
    assign lvl    = r_lvl;
    assign afull  = (r_lvl >= c_AFT);
    assign aempty = (r_lvl <= c_AET);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_ram[r_wrptr] <= wrdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrptr <= '0;
            r_rdptr <= '0;
            r_lvl   <= '0;
        end else if (clr) begin
            r_wrptr <= '0;
            r_rdptr <= '0;
            r_lvl   <= '0;
        end else begin
            if (w_wr) begin
                r_wrptr <= f_inc(r_wrptr);
            end
            if (w_rpop) begin
                r_rdptr <= f_inc(r_rdptr);
            end
            if (w_wr && !w_rd) begin
                r_lvl <= r_lvl + LW'(1);
            end else if (!w_wr && w_rd) begin
                r_lvl <= r_lvl - LW'(1);
            end
        end
    end

    if (EOREG != 0) begin : g_oreg
        localparam int RW = $clog2(D + 1);
        logic [RW-1:0] r_ramcnt;
        logic          r_ovld;
        logic [W-1:0]  r_odata;

        // Head register refills from RAM whenever it is empty or being consumed.
        assign w_rpop = (r_ramcnt != '0) && (!r_ovld || w_rd);
        assign w_hvld = r_ovld;
        assign rddata = r_odata;

        always_ff @(posedge clk) begin
            if (w_rpop) begin
                r_odata <= w_ramq;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ramcnt <= '0;
                r_ovld   <= 1'b0;
            end else if (clr) begin
                r_ramcnt <= '0;
                r_ovld   <= 1'b0;
            end else begin
                if (w_wr && !w_rpop) begin
                    r_ramcnt <= r_ramcnt + RW'(1);
                end else if (!w_wr && w_rpop) begin
                    r_ramcnt <= r_ramcnt - RW'(1);
                end
                if (w_rpop) begin
                    r_ovld <= 1'b1;
                end else if (w_rd) begin
                    r_ovld <= 1'b0;
                end
            end
        end
    end else begin : g_noreg
        assign w_rpop = w_rd;
        assign w_hvld = (r_lvl != '0);
        assign rddata = w_ramq;
    end

endmodule

`default_nettype wire

// File: tb/tb_powlib_sfifo_lvl.sv
// Bench for powlib_sfifo_lvl: three instances (D=5 fall-through, D=4 registered
// output, D=4 fall-through) driven by directed steps against a reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_powlib_sfifo_lvl;

    localparam int PD  [3] = '{5, 4, 4};
    localparam int PE  [3] = '{0, 1, 0};
    localparam int PAFT[3] = '{4, 4, 3};
    localparam int PAET[3] = '{1, 1, 1};

    logic       clk = 1'b0;
    logic       rst [3];
    logic       clr [3];
    logic [7:0] wd  [3];
    logic       wv  [3];
    logic       wr  [3];
    logic [7:0] rd  [3];
    logic       rv  [3];
    logic       rr  [3];
    logic [2:0] lv  [3];
    logic       af  [3];
    logic       ae  [3];

    always #5 clk = ~clk;

    powlib_sfifo_lvl #(.W(8), .D(5), .EOREG(0), .AFT(4), .AET(1), .EDBG(1), .ID("A")) u_a (
        .clk(clk), .rst(rst[0]), .clr(clr[0]), .wrdata(wd[0]), .wrvld(wv[0]), .wrrdy(wr[0]),
        .rddata(rd[0]), .rdvld(rv[0]), .rdrdy(rr[0]), .lvl(lv[0]), .afull(af[0]), .aempty(ae[0]));

    powlib_sfifo_lvl #(.W(8), .D(4), .EOREG(1), .AFT(4), .AET(1), .EDBG(1), .ID("B")) u_b (
        .clk(clk), .rst(rst[1]), .clr(clr[1]), .wrdata(wd[1]), .wrvld(wv[1]), .wrrdy(wr[1]),
        .rddata(rd[1]), .rdvld(rv[1]), .rdrdy(rr[1]), .lvl(lv[1]), .afull(af[1]), .aempty(ae[1]));

    powlib_sfifo_lvl #(.W(8), .D(4), .EOREG(0), .AFT(3), .AET(1), .EDBG(1), .ID("C")) u_c (
        .clk(clk), .rst(rst[2]), .clr(clr[2]), .wrdata(wd[2]), .wrvld(wv[2]), .wrrdy(wr[2]),
        .rddata(rd[2]), .rdvld(rv[2]), .rdrdy(rr[2]), .lvl(lv[2]), .afull(af[2]), .aempty(ae[2]));

    int         nvec = 0;
    int         nmis = 0;
    logic [7:0] sb[$];
    int         mlvl;
    int         mram;
    bit         movld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        mlvl  = 0;
        mram  = 0;
        movld = 1'b0;
        sb.delete();
    endtask

    // One clock cycle on instance k: drive, check against model, advance model.
    task automatic step(input int k, input bit iwv, input logic [7:0] iwd, input bit irr, input bit icl);
        bit ewr, erv, w, r, pop;
        wv[k] = iwv; wd[k] = iwd; rr[k] = irr; clr[k] = icl;
        #1;
        ewr = (mlvl != PD[k] + PE[k]) && !icl;
        erv = ((PE[k] != 0) ? movld : (mlvl != 0)) && !icl;
        chk($sformatf("wrrdy[%0d]", k), 32'(wr[k]), 32'(ewr));
        chk($sformatf("rdvld[%0d]", k), 32'(rv[k]), 32'(erv));
        chk($sformatf("lvl[%0d]", k), 32'(lv[k]), 32'(mlvl));
        chk($sformatf("afull[%0d]", k), 32'(af[k]), 32'(mlvl >= PAFT[k]));
        chk($sformatf("aempty[%0d]", k), 32'(ae[k]), 32'(mlvl <= PAET[k]));
        if (erv && sb.size() > 0) begin
            chk($sformatf("rddata[%0d]", k), 32'(rd[k]), 32'(sb[0]));
        end
        w = iwv && ewr;
        r = irr && erv;
        if (r) void'(sb.pop_front());
        if (w) sb.push_back(iwd);
        if (icl) begin
            mreset();
        end else begin
            pop   = (mram != 0) && (!movld || r);
            mlvl  = mlvl + int'(w) - int'(r);
            mram  = mram + int'(w) - int'(pop);
            if (pop) movld = 1'b1;
            else if (r) movld = 1'b0;
        end
        @(posedge clk);
        #1;
        wv[k] = 1'b0; rr[k] = 1'b0; clr[k] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; clr[k] = 1'b0; wv[k] = 1'b0; rr[k] = 1'b0; wd[k] = '0;
        end
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("rst_lvl", 32'(lv[k]), 32'd0);
            chk("rst_wrrdy", 32'(wr[k]), 32'd1);
            chk("rst_rdvld", 32'(rv[k]), 32'd0);
            chk("rst_afull", 32'(af[k]), 32'd0);
            chk("rst_aempty", 32'(ae[k]), 32'd1);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        // Non-power-of-2 depth fill, blocked 6th write, in-order drain.
        mreset();
        for (int i = 1; i <= 5; i++) step(0, 1, 8'(i), 0, 0);
        step(0, 1, 8'h06, 0, 0);
        step(0, 1, 8'h06, 1, 0);
        step(0, 1, 8'h06, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 0);

        // Continuous streaming through several pointer wraps.
        mreset();
        for (int i = 0; i < 20; i++) step(0, 1, 8'(i), 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);

        // Registered output: 2-cycle latency, capacity D+1, hold under back-pressure.
        mreset();
        step(1, 1, 8'hAA, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 4; i++) step(1, 1, 8'(8'hB0 + i), 0, 0);
        step(1, 1, 8'hBF, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 8'h00, 1, 0);

        // Full with simultaneous write and read requests.
        mreset();
        for (int i = 0; i < 4; i++) step(2, 1, 8'(8'h10 + i), 0, 0);
        step(2, 1, 8'h14, 1, 0);
        step(2, 1, 8'h14, 1, 0);
        step(2, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) step(2, 0, 8'h00, 1, 0);

        // Synchronous flush.
        mreset();
        for (int i = 1; i <= 3; i++) step(0, 1, 8'(8'h20 + i), 0, 0);
        step(0, 1, 8'h99, 1, 1);
        step(0, 0, 8'h00, 0, 0);
        step(0, 1, 8'h55, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);

        // Asynchronous reset between clock edges.
        mreset();
        for (int i = 1; i <= 3; i++) step(0, 1, 8'(8'h30 + i), 0, 0);
        #1 rst[0] = 1'b1;
        #2;
        chk("arst_lvl", 32'(lv[0]), 32'd0);
        chk("arst_rdvld", 32'(rv[0]), 32'd0);
        chk("arst_wrrdy", 32'(wr[0]), 32'd1);
        chk("arst_aempty", 32'(ae[0]), 32'd1);
        rst[0] = 1'b0;
        mreset();
        @(negedge clk);
        step(0, 1, 8'h77, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

`default_nettype wire
